// File: rtl/trap_pkg.sv
// Shared types and constants for the trap sequencer.
//   trap_state_t : sequencer FSM states
//   MSTATUS_*    : mstatus CSR address and field positions
package trap_pkg;

  typedef enum logic [1:0] {
    TS_IDLE,
    TS_DRAIN,
    TS_REDIRECT
  } trap_state_t;

  localparam logic [11:0] MSTATUS_ADDR      = 12'h300;
  localparam int          MSTATUS_MIE_BIT   = 3;
  localparam int          MSTATUS_MPIE_BIT  = 7;
  localparam int          MSTATUS_MPP_LSB   = 11;
  localparam logic [1:0]  MPP_MACHINE       = 2'b11;

endpackage

// File: rtl/flopre.sv
// Resettable, enabled D flip-flop bank.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; clears q
//   en    : load enable
//   d     : data in
//   q     : registered data out
module flopre #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry / MRET sequencer. Takes a trap request or MRET while idle,
// holds flush for DRAIN_CYCLES cycles, then flushes with a one-cycle PC
// redirect to the latched target. Owns mstatus.MIE/MPIE (MPP fixed at M).
//   clk, reset             : clock, async active-high reset
//   trapTrigger            : per-cause trap request (already MIE-masked)
//   mtvec, mepc            : trap vector base / saved exception PC
//   mret                   : MRET valid in decode
//   CSR_In/addr/WriteEnable: CSR write port (only mstatus decoded)
//   MIE, mstatus           : mstatus.MIE and full mstatus read value
//   flush, redirect        : pipeline squash and one-cycle PC override
//   redirectPC             : override target, zero when redirect=0
//   busy                   : sequence in progress
//
// state       | meaning
// TS_IDLE     | waiting for trap / mret; mstatus writable
// TS_DRAIN    | flushing in-flight stages, counting DRAIN_CYCLES
// TS_REDIRECT | flush plus PC override to latched target
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int   N            = 64,
  parameter int   DRAIN_CYCLES = 2,
  parameter logic MIE_RESET    = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  trapTrigger,
  input  logic [N-1:0] mtvec,
  input  logic [N-1:0] mepc,
  input  logic         mret,
  input  logic [N-1:0] CSR_In,
  input  logic [11:0]  CSR_addr,
  input  logic         CSR_WriteEnable,
  output logic         MIE,
  output logic [N-1:0] mstatus,
  output logic         flush,
  output logic         redirect,
  output logic [N-1:0] redirectPC,
  output logic         busy
);

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  trap_state_t state, state_next;
  logic [3:0]  count, count_next;
  logic        take_trap, take_mret, csr_wr;
  logic        mie_q, mpie_q;
  logic [N-1:0] target, target_d;

  // Low PC bits and unused CSR data bits are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{mtvec[1:0], mepc[1:0]} ^ ^CSR_In;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= TS_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    take_trap  = 1'b0;
    take_mret  = 1'b0;
    csr_wr     = 1'b0;
    case (state)
      TS_IDLE: begin
        count_next = '0;
        if (|trapTrigger) begin
          take_trap  = 1'b1;
          state_next = TS_DRAIN;
        end else if (mret) begin
          take_mret  = 1'b1;
          state_next = TS_DRAIN;
        end else if (CSR_WriteEnable && (CSR_addr == MSTATUS_ADDR)) begin
          csr_wr = 1'b1;
        end
      end
      TS_DRAIN: begin
        if (count == DRAIN_LAST) begin
          state_next = TS_REDIRECT;
          count_next = '0;
        end else begin
          count_next = count + 4'd1;
        end
      end
      TS_REDIRECT: begin
        state_next = TS_IDLE;
        count_next = '0;
      end
      default: begin
        state_next = TS_IDLE;
        count_next = '0;
      end
    endcase
  end

  // Trap and MRET targets are word-aligned; bits [1:0] forced to zero.
  assign target_d = take_trap ? {mtvec[N-1:2], 2'b00} : {mepc[N-1:2], 2'b00};

  flopre #(.WIDTH(N)) u_target (
    .clk   (clk),
    .reset (reset),
    .en    (take_trap | take_mret),
    .d     (target_d),
    .q     (target)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mie_q  <= MIE_RESET;
      mpie_q <= 1'b0;
    end else if (take_trap) begin
      mpie_q <= mie_q;
      mie_q  <= 1'b0;
    end else if (take_mret) begin
      mie_q  <= mpie_q;
      mpie_q <= 1'b1;
    end else if (csr_wr) begin
      mie_q  <= CSR_In[MSTATUS_MIE_BIT];
      mpie_q <= CSR_In[MSTATUS_MPIE_BIT];
    end
  end

  always_comb begin
    mstatus                                       = '0;
    mstatus[MSTATUS_MPP_LSB+1:MSTATUS_MPP_LSB]    = MPP_MACHINE;
    mstatus[MSTATUS_MPIE_BIT]                     = mpie_q;
    mstatus[MSTATUS_MIE_BIT]                      = mie_q;
  end

  // All outputs decode from registered state, so reset drops them at once.
  assign MIE        = mie_q;
  assign busy       = (state != TS_IDLE);
  assign flush      = (state != TS_IDLE);
  assign redirect   = (state == TS_REDIRECT);
  assign redirectPC = (state == TS_REDIRECT) ? target : '0;

endmodule
